bp_be_mt_scheduler: RTL and testbench

Parametrised multi-thread scheduler for the BE, replacing the fixed round-robin thread scheduler. It tracks per-thread enable and blocked state and selects the running thread. Switches are triggered by CSR-forced requests, blocking events, or time-slice expiry. Each switch uses a drain handshake with the director, and a commit pulse drives context save and restore in the context storage.

---
 rtl/bp_be_mt_pkg.sv | 23 ++
 rtl/bp_be_mt_rr_picker.sv | 37 +++
 rtl/bp_be_mt_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_bp_be_mt_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_mt_pkg.sv
// Shared types and constants for the BE multi-thread scheduler.
`default_nettype none

package bp_be_mt_pkg;

  localparam int bp_be_mt_max_threads_gp = 16;

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_drain = 2'd1,
    e_idle  = 2'd2
  } bp_be_mt_state_e;

  typedef enum logic [1:0] {
    e_cause_csr     = 2'd0,
    e_cause_block   = 2'd1,
    e_cause_quantum = 2'd2,
    e_cause_wake    = 2'd3
  } bp_be_mt_cause_e;

endpackage

`default_nettype wire

// File: rtl/bp_be_mt_rr_picker.sv
// Rotating-priority picker: first runnable thread at or after start_i, with wrap.
`default_nettype none

module bp_be_mt_rr_picker
#(
  parameter int num_threads_p     = 4,
  parameter int thread_id_width_p = $clog2(num_threads_p)
)
(
  input  logic [num_threads_p-1:0]     runnable_i,
  input  logic [thread_id_width_p-1:0] start_i,
  output logic [thread_id_width_p-1:0] pick_o,
  output logic                         pick_v_o
);

  logic [thread_id_width_p-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest runnable thread wins.
  always_comb begin
    pick_o   = '0;
    pick_v_o = 1'b0;
    idx      = '0;
    for (int i = num_threads_p-1; i >= 0; i--) begin
      if (int'(start_i) + i >= num_threads_p)
        idx = thread_id_width_p'(int'(start_i) + i - num_threads_p);
      else
        idx = thread_id_width_p'(int'(start_i) + i);
      if (runnable_i[idx]) begin
        pick_o   = idx;
        pick_v_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_be_mt_scheduler.sv
// BE multi-thread scheduler with drain handshake; time-slice preemption under BP_BE_MT_QUANTUM_EN.
`default_nettype none

module bp_be_mt_scheduler
  import bp_be_mt_pkg::*;
#(
  parameter int num_threads_p     = 4,
  parameter int thread_id_width_p = $clog2(num_threads_p),
  parameter int quantum_width_p   = 16,
  parameter int reset_quantum_p   = 1024
)
(
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         enable_w_v_i,
  input  logic [thread_id_width_p-1:0] enable_w_tid_i,
  input  logic                         enable_w_val_i,
  input  logic                         block_v_i,
  input  logic                         wake_v_i,
  input  logic [thread_id_width_p-1:0] wake_tid_i,
  input  logic                         csr_switch_v_i,
  input  logic [thread_id_width_p-1:0] csr_switch_tid_i,
  input  logic                         quantum_w_v_i,
  input  logic [quantum_width_p-1:0]   quantum_i,
  input  logic                         drained_i,
  output logic [thread_id_width_p-1:0] thread_id_o,
  output logic                         thread_v_o,
  output logic                         switch_req_o,
  output logic                         switch_commit_o,
  output logic [thread_id_width_p-1:0] prev_thread_id_o,
  output logic [1:0]                   switch_cause_o
);

  localparam logic [thread_id_width_p-1:0] last_tid_lp = thread_id_width_p'(num_threads_p-1);

  bp_be_mt_state_e              state_q, state_d;
  bp_be_mt_cause_e              cause_q, cause_d, pend_cause_q, pend_cause_d;
  logic [thread_id_width_p-1:0] tid_q, tid_d, prev_q, prev_d, csr_tgt_q, csr_tgt_d;
  logic                         csr_tgt_v_q, csr_tgt_v_d;
  logic                         v_q, v_d, req_q, req_d, commit_q, commit_d;
  logic [num_threads_p-1:0]     enable_q, enable_d, blocked_q, blocked_d, runnable_d;

  logic [thread_id_width_p-1:0] w_start, w_rr_pick;
  logic                         w_rr_pick_v;
  logic [num_threads_p-1:0]     w_cur_oh;
  logic                         w_other_runnable, w_q_expire;
  logic                         w_csr_trig, w_blk_trig, w_dis_trig, w_q_trig;

  // Block is applied after wake so a same-cycle block on the woken thread wins.
  always_comb begin
    enable_d = enable_q;
    if (enable_w_v_i)
      enable_d[enable_w_tid_i] = enable_w_val_i;
    blocked_d = blocked_q;
    if (wake_v_i)
      blocked_d[wake_tid_i] = 1'b0;
    if (block_v_i && v_q)
      blocked_d[tid_q] = 1'b1;
    runnable_d = enable_d & ~blocked_d;
  end

  assign w_start          = (tid_q == last_tid_lp) ? '0 : tid_q + 1'b1;
  assign w_cur_oh         = num_threads_p'(1) << tid_q;
  assign w_other_runnable = |(runnable_d & ~w_cur_oh);

  bp_be_mt_rr_picker #(
    .num_threads_p     (num_threads_p),
    .thread_id_width_p (thread_id_width_p)
  ) u_picker (
    .runnable_i (runnable_d),
    .start_i    (w_start),
    .pick_o     (w_rr_pick),
    .pick_v_o   (w_rr_pick_v)
  );

  assign w_csr_trig = csr_switch_v_i && (csr_switch_tid_i != tid_q);
  assign w_blk_trig = block_v_i;
  assign w_dis_trig = enable_w_v_i && !enable_w_val_i && (enable_w_tid_i == tid_q);
  assign w_q_trig   = w_q_expire && w_other_runnable;

`ifdef BP_BE_MT_QUANTUM_EN
  logic [quantum_width_p-1:0] quantum_q, quantum_d, reload_q, reload_d;
  logic                       w_q_reload;

  // Expiry fires on the cycle the counter steps to zero, giving reload-many run cycles.
  assign w_q_expire = (quantum_q <= quantum_width_p'(1));
  assign w_q_reload = (state_q == e_run) && w_q_expire && !w_other_runnable;

  always_comb begin
    reload_d  = quantum_w_v_i ? quantum_i : reload_q;
    quantum_d = quantum_q;
    if (commit_d || w_q_reload)
      quantum_d = reload_q;
    else if ((state_q == e_run) && (quantum_q != '0))
      quantum_d = quantum_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      quantum_q <= quantum_width_p'(reset_quantum_p);
      reload_q  <= quantum_width_p'(reset_quantum_p);
    end else begin
      quantum_q <= quantum_d;
      reload_q  <= reload_d;
    end
  end
`else
  logic w_unused_quantum;
  assign w_q_expire       = 1'b0;
  assign w_unused_quantum = ^{quantum_w_v_i, quantum_i, quantum_width_p'(reset_quantum_p)};
`endif

  always_comb begin
    state_d      = state_q;
    tid_d        = tid_q;
    prev_d       = prev_q;
    cause_d      = cause_q;
    pend_cause_d = pend_cause_q;
    csr_tgt_d    = csr_tgt_q;
    csr_tgt_v_d  = csr_tgt_v_q;
    commit_d     = 1'b0;
    case (state_q)
      e_run: begin
        if (w_csr_trig) begin
          state_d      = e_drain;
          pend_cause_d = e_cause_csr;
          csr_tgt_d    = csr_switch_tid_i;
          csr_tgt_v_d  = 1'b1;
        end else if (w_blk_trig || w_dis_trig) begin
          state_d      = e_drain;
          pend_cause_d = e_cause_block;
          csr_tgt_v_d  = 1'b0;
        end else if (w_q_trig) begin
          state_d      = e_drain;
          pend_cause_d = e_cause_quantum;
          csr_tgt_v_d  = 1'b0;
        end
      end
      e_drain: begin
        if (drained_i) begin
          csr_tgt_v_d = 1'b0;
          if (csr_tgt_v_q && runnable_d[csr_tgt_q]) begin
            state_d  = e_run;
            tid_d    = csr_tgt_q;
            prev_d   = tid_q;
            cause_d  = pend_cause_q;
            commit_d = 1'b1;
          end else if (w_rr_pick_v) begin
            state_d  = e_run;
            tid_d    = w_rr_pick;
            prev_d   = tid_q;
            cause_d  = pend_cause_q;
            commit_d = 1'b1;
          end else begin
            state_d = e_idle;
          end
        end
      end
      e_idle: begin
        if (w_rr_pick_v) begin
          state_d  = e_run;
          tid_d    = w_rr_pick;
          prev_d   = tid_q;
          cause_d  = e_cause_wake;
          commit_d = 1'b1;
        end
      end
      default: state_d = e_run;
    endcase
    req_d = (state_d == e_drain);
    v_d   = (state_d != e_idle);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_run;
      tid_q        <= '0;
      prev_q       <= '0;
      cause_q      <= e_cause_csr;
      pend_cause_q <= e_cause_csr;
      csr_tgt_q    <= '0;
      csr_tgt_v_q  <= 1'b0;
      v_q          <= 1'b1;
      req_q        <= 1'b0;
      commit_q     <= 1'b0;
      enable_q     <= num_threads_p'(1);
      blocked_q    <= '0;
    end else begin
      state_q      <= state_d;
      tid_q        <= tid_d;
      prev_q       <= prev_d;
      cause_q      <= cause_d;
      pend_cause_q <= pend_cause_d;
      csr_tgt_q    <= csr_tgt_d;
      csr_tgt_v_q  <= csr_tgt_v_d;
      v_q          <= v_d;
      req_q        <= req_d;
      commit_q     <= commit_d;
      enable_q     <= enable_d;
      blocked_q    <= blocked_d;
    end
  end

  assign thread_id_o      = tid_q;
  assign thread_v_o       = v_q;
  assign switch_req_o     = req_q;
  assign switch_commit_o  = commit_q;
  assign prev_thread_id_o = prev_q;
  assign switch_cause_o   = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_mt_scheduler.sv
// Directed self-checking bench for bp_be_mt_scheduler (4 threads).
`default_nettype none

module tb_bp_be_mt_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_w_v = 1'b0;
  logic [1:0] enable_w_tid = '0;
  logic       enable_w_val = 1'b0;
  logic       block_v = 1'b0;
  logic       wake_v = 1'b0;
  logic [1:0] wake_tid = '0;
  logic       csr_v = 1'b0;
  logic [1:0] csr_tid = '0;
  logic       quantum_w_v = 1'b0;
  logic [15:0] quantum = '0;
  logic       drained = 1'b0;
  logic [1:0] thread_id;
  logic       thread_v;
  logic       switch_req;
  logic       switch_commit;
  logic [1:0] prev_tid;
  logic [1:0] cause;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_be_mt_scheduler dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .enable_w_v_i     (enable_w_v),
    .enable_w_tid_i   (enable_w_tid),
    .enable_w_val_i   (enable_w_val),
    .block_v_i        (block_v),
    .wake_v_i         (wake_v),
    .wake_tid_i       (wake_tid),
    .csr_switch_v_i   (csr_v),
    .csr_switch_tid_i (csr_tid),
    .quantum_w_v_i    (quantum_w_v),
    .quantum_i        (quantum),
    .drained_i        (drained),
    .thread_id_o      (thread_id),
    .thread_v_o       (thread_v),
    .switch_req_o     (switch_req),
    .switch_commit_o  (switch_commit),
    .prev_thread_id_o (prev_tid),
    .switch_cause_o   (cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_enable(input logic [1:0] t, input logic val);
    enable_w_v = 1'b1; enable_w_tid = t; enable_w_val = val;
    step();
    enable_w_v = 1'b0;
  endtask

  task automatic check_commit(input string tag, input logic [1:0] tid, input logic [1:0] prev,
                              input logic [1:0] cs);
    check({tag, ".commit"}, switch_commit, 1);
    check({tag, ".tid"}, thread_id, tid);
    check({tag, ".prev"}, prev_tid, prev);
    check({tag, ".cause"}, cause, cs);
    check({tag, ".req"}, switch_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values observed while reset is held
    #12;
    check("rst.tid", thread_id, 0);
    check("rst.v", thread_v, 1);
    check("rst.req", switch_req, 0);
    check("rst.commit", switch_commit, 0);
    check("rst.prev", prev_tid, 0);
    check("rst.cause", cause, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // CSR switch 0 -> 1, drained two cycles after the trigger
    set_enable(2'd1, 1'b1);
    csr_v = 1'b1; csr_tid = 2'd1;
    step();
    csr_v = 1'b0;
    check("csr.req1", switch_req, 1);
    step();
    check("csr.req2", switch_req, 1);
    check("csr.nocommit", switch_commit, 0);
    drained = 1'b1;
    step();
    drained = 1'b0;
    check_commit("csr", 2'd1, 2'd0, 2'd0);
    step();
    check("csr.pulse_end", switch_commit, 0);

    // Move to thread 2, then block it with every other thread disabled
    set_enable(2'd2, 1'b1);
    csr_v = 1'b1; csr_tid = 2'd2;
    step();
    csr_v = 1'b0; drained = 1'b1;
    step();
    drained = 1'b0;
    check_commit("to2", 2'd2, 2'd1, 2'd0);
    set_enable(2'd0, 1'b0);
    set_enable(2'd1, 1'b0);
    check("dis_other.req", switch_req, 0);
    block_v = 1'b1;
    step();
    block_v = 1'b0;
    check("blk.req", switch_req, 1);
    drained = 1'b1;
    step();
    drained = 1'b0;
    check("idle.v", thread_v, 0);
    check("idle.req", switch_req, 0);
    check("idle.commit", switch_commit, 0);
    step();
    check("idle.v2", thread_v, 0);
    wake_v = 1'b1; wake_tid = 2'd2;
    step();
    wake_v = 1'b0;
    check("wake.v", thread_v, 1);
    check_commit("wake", 2'd2, 2'd2, 2'd3);

    // CSR target 3 disabled while draining: round-robin from 3 lands on 0
    set_enable(2'd3, 1'b1);
    set_enable(2'd0, 1'b1);
    csr_v = 1'b1; csr_tid = 2'd3;
    step();
    csr_v = 1'b0;
    check("tgt3.req", switch_req, 1);
    set_enable(2'd3, 1'b0);
    check("tgt3.req_hold", switch_req, 1);
    drained = 1'b1;
    step();
    drained = 1'b0;
    check_commit("tgt3", 2'd0, 2'd2, 2'd0);

    // Same-cycle CSR and block: CSR cause, thread 0 left blocked
    set_enable(2'd1, 1'b1);
    csr_v = 1'b1; csr_tid = 2'd1; block_v = 1'b1;
    step();
    csr_v = 1'b0; block_v = 1'b0;
    check("csrblk.req", switch_req, 1);
    drained = 1'b1;
    step();
    drained = 1'b0;
    check_commit("csrblk", 2'd1, 2'd0, 2'd0);
    csr_v = 1'b1; csr_tid = 2'd0;
    step();
    csr_v = 1'b0;
    drained = 1'b1;
    step();
    drained = 1'b0;
    check_commit("blocked0", 2'd2, 2'd1, 2'd0);
    csr_v = 1'b1; csr_tid = 2'd2;
    step();
    csr_v = 1'b0;
    check("self.req", switch_req, 0);
    step();
    check("self.req2", switch_req, 0);
    check("self.tid", thread_id, 2);

    // Asynchronous reset in the middle of a drain
    csr_v = 1'b1; csr_tid = 2'd1;
    step();
    csr_v = 1'b0;
    check("mid.req", switch_req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst.tid", thread_id, 0);
    check("arst.v", thread_v, 1);
    check("arst.req", switch_req, 0);
    check("arst.commit", switch_commit, 0);
    check("arst.prev", prev_tid, 0);
    check("arst.cause", cause, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    check("post.tid", thread_id, 0);
    check("post.v", thread_v, 1);
    check("post.req", switch_req, 0);

`ifdef BP_BE_MT_QUANTUM_EN
    // Quantum rotation with reload 8 and drained tied high
    quantum_w_v = 1'b1; quantum = 16'd8;
    step();
    quantum_w_v = 1'b0;
    set_enable(2'd1, 1'b1);
    set_enable(2'd2, 1'b1);
    set_enable(2'd3, 1'b1);
    drained = 1'b1;
    csr_v = 1'b1; csr_tid = 2'd1;
    step();
    csr_v = 1'b0;
    step();
    check_commit("q.start", 2'd1, 2'd0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      step(7);
      check("q.req_early", switch_req, 0);
      step();
      check("q.req", switch_req, 1);
      step();
      check_commit("q.sw", 2'((k + 2) % 4), 2'((k + 1) % 4), 2'd2);
    end
    drained = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
